// File: rtl/right_shift_by_amount_sequential_pkg.sv
// Shared types and helpers for the sequential right shifter.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (arithmetic sign fill).
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  // Amounts at or beyond the data width all produce a fully filled word,
  // so the iteration count never needs to exceed the width.
  function automatic int unsigned clamp_shamt(input int unsigned amount,
                                              input int unsigned n);
    return (amount > n) ? n : amount;
  endfunction

endpackage

// File: rtl/right_shift_by_amount_sequential_if.sv
// Upstream/downstream valid-ready bundle for the sequential right shifter.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (up_arith only matters then).
interface right_shift_by_amount_sequential_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
);

  logic          up_vld;
  logic          up_rdy;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_arith;
  logic          down_vld;
  logic          down_rdy;
  logic [N-1:0]  down_data;

  // Producer of operands / consumer of results
  modport master (
    output up_vld, up_data, up_shamt, up_arith, down_rdy,
    input  up_rdy, down_vld, down_data
  );

  // The shifter itself
  modport slave (
    input  up_vld, up_data, up_shamt, up_arith, down_rdy,
    output up_rdy, down_vld, down_data
  );

endinterface

// File: rtl/right_shift_by_amount_sequential_step.sv
// One-bit right shift with an explicit fill bit entering at the MSB.
// Optional feature macro: SHIFT_SEQ_ARITH_EN (decides the fill upstream).
module shift_right_one_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         fill,
  output logic [N-1:0] shifted
);

  assign shifted = {fill, data[N-1:1]};

endmodule

// File: rtl/right_shift_by_amount_sequential.sv
// Iterative right shifter: one bit per cycle, runtime amount, valid/ready
// on both sides, one operation in flight.
// Optional feature macro: SHIFT_SEQ_ARITH_EN -- when defined, up_arith
// selects sign fill captured at accept; otherwise the fill is always 0.
module right_shift_by_amount_sequential
  import shift_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input logic                              clk,
  input logic                              rst_n,
  right_shift_by_amount_sequential_if.slave bus
);

  localparam int unsigned NU = N;

  shift_state_t  state_r;
  shift_state_t  state_nxt;
  logic [N-1:0]  data_r;
  logic [N-1:0]  out_r;
  logic          fill_r;
  logic [SW-1:0] cnt_r;
  logic [SW-1:0] cnt_load;
  logic          fill_in;
  logic [N-1:0]  shifted;
  logic          accept;

  assign cnt_load = SW'(clamp_shamt(32'(bus.up_shamt), NU));
  assign accept   = bus.up_vld && (state_r == IDLE);

`ifdef SHIFT_SEQ_ARITH_EN
  assign fill_in = bus.up_arith ? bus.up_data[N-1] : 1'b0;
`else
  // Logical-only build: the arithmetic select is deliberately ignored.
  logic unused_arith;
  assign unused_arith = bus.up_arith;
  assign fill_in      = 1'b0;
`endif

  shift_right_one_step #(.N(N)) u_step (
    .data    (data_r),
    .fill    (fill_r),
    .shifted (shifted)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state_r;
    bus.up_rdy   = 1'b0;
    bus.down_vld = 1'b0;
    case (state_r)
      IDLE: begin
        bus.up_rdy = 1'b1;
        if (bus.up_vld) state_nxt = (cnt_load == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        // This shift brings the count to zero.
        if (cnt_r == SW'(1)) state_nxt = DONE;
      end
      DONE: begin
        bus.down_vld = 1'b1;
        if (bus.down_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-cycle shift, and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      out_r  <= '0;
      fill_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept) begin
            data_r <= bus.up_data;
            fill_r <= fill_in;
            cnt_r  <= cnt_load;
            if (cnt_load == '0) out_r <= bus.up_data;
          end
        end
        SHIFT: begin
          data_r <= shifted;
          cnt_r  <= cnt_r - SW'(1);
          // Result register only moves when the final shift lands, so the
          // downstream value stays put outside DONE.
          if (cnt_r == SW'(1)) out_r <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.down_data = out_r;

endmodule
